// File: rtl/battery_discharge_controller.sv
// battery_discharge_controller
// Meters battery drain while a load runs: a prescaled drain tick removes a
// mode-dependent percentage from battery_level, the load is throttled below
// LOW_THRESH and disconnected at CUTOFF_LEVEL. level_load/level_in resync the
// level from the charger side.
// Optional feature: define DRAIN_ACCOUNTING_EN to add the consumed_total port
// and its saturating drain counter.
module battery_discharge_controller #(
   parameter int INIT_LEVEL   = 100,
   parameter int LOW_THRESH   = 20,
   parameter int CUTOFF_LEVEL = 5,
   parameter int TICK_DIV     = 4,
   parameter int CNT_W        = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             charger_plugged,
   input  logic             load_request,
   input  logic [1:0]       load_mode,
   input  logic             level_load,
   input  logic [7:0]       level_in,
   output logic [7:0]       battery_level,
   output logic             load_enable,
   output logic             low_battery,
   output logic             drain_tick,
   output logic [1:0]       present_state
`ifdef DRAIN_ACCOUNTING_EN
   ,
   output logic [CNT_W-1:0] consumed_total
`endif
);

   localparam logic [1:0] S_IDLE      = 2'b00;
   localparam logic [1:0] S_DISCHARGE = 2'b01;
   localparam logic [1:0] S_LOW_POWER = 2'b10;
   localparam logic [1:0] S_CUTOFF    = 2'b11;

   localparam logic [7:0] LVL_INIT = 8'(INIT_LEVEL);
   localparam logic [7:0] LVL_LOW  = 8'(LOW_THRESH);
   localparam logic [7:0] LVL_CUT  = 8'(CUTOFF_LEVEL);
   localparam logic [7:0] LVL_MAX  = 8'd100;

   localparam int         PW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);

   // Level subtraction that stops at empty instead of wrapping to 255.
   function automatic logic [7:0] sat_sub(input logic [7:0] a, input logic [1:0] b);
      if (a > {6'd0, b}) return a - {6'd0, b};
      else               return 8'd0;
   endfunction

   // Levels coming from the charger side are clamped to a full battery.
   function automatic logic [7:0] clamp_level(input logic [7:0] v);
      if (v > LVL_MAX) return LVL_MAX;
      else             return v;
   endfunction

   logic [1:0]    state_q, state_d;
   logic [7:0]    level_q, level_d;
   logic          load_en_q, load_en_d;
   logic          low_q, low_d;
   logic          tick_q, tick_d;
   logic [PW-1:0] presc_q, presc_d;
   logic          active;
   logic          wrap;
   logic          run_req;
   logic [1:0]    rate;

   assign run_req = load_request && (load_mode != 2'b00);

   // Next-state selection, evaluated on the pre-edge level.
   always_comb begin
      state_d = state_q;
      if (charger_plugged) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (run_req) begin
                  if (level_q <= LVL_CUT)      state_d = S_CUTOFF;
                  else if (level_q <= LVL_LOW) state_d = S_LOW_POWER;
                  else                         state_d = S_DISCHARGE;
               end
            end
            S_DISCHARGE: begin
               if (!run_req)                state_d = S_IDLE;
               else if (level_q <= LVL_LOW) state_d = S_LOW_POWER;
            end
            S_LOW_POWER: begin
               if (!run_req)                state_d = S_IDLE;
               else if (level_q <= LVL_CUT) state_d = S_CUTOFF;
            end
            default: state_d = S_CUTOFF;
         endcase
      end
      load_en_d = (state_d == S_DISCHARGE) || (state_d == S_LOW_POWER);
   end

   // Prescaler, drain rate and level update; a level load overrides a tick.
   always_comb begin
      active  = (state_q == S_DISCHARGE) || (state_q == S_LOW_POWER);
      wrap    = active && (presc_q == PMAX) && !level_load;
      presc_d = presc_q;
      if (!active || level_load) presc_d = '0;
      else if (presc_q == PMAX)  presc_d = '0;
      else                       presc_d = presc_q + 1'b1;

      rate = 2'd0;
      if (state_q == S_DISCHARGE)      rate = load_mode;
      else if (state_q == S_LOW_POWER) rate = (load_mode != 2'b00) ? 2'd1 : 2'd0;

      level_d = level_q;
      if (level_load) level_d = clamp_level(level_in);
      else if (wrap)  level_d = sat_sub(level_q, rate);

      tick_d = wrap;
      low_d  = (level_d <= LVL_LOW);
   end

   // Registered state, level and outputs with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_IDLE;
         level_q   <= LVL_INIT;
         load_en_q <= 1'b0;
         low_q     <= (LVL_INIT <= LVL_LOW);
         tick_q    <= 1'b0;
         presc_q   <= '0;
      end else begin
         state_q   <= state_d;
         level_q   <= level_d;
         load_en_q <= load_en_d;
         low_q     <= low_d;
         tick_q    <= tick_d;
         presc_q   <= presc_d;
      end
   end

   assign battery_level = level_q;
   assign load_enable   = load_en_q;
   assign low_battery   = low_q;
   assign drain_tick    = tick_q;
   assign present_state = state_q;

`ifdef DRAIN_ACCOUNTING_EN
   // Counter growth that sticks at all-ones instead of wrapping.
   function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [7:0] b);
      logic [CNT_W:0] sum;
      sum = {1'b0, a} + (CNT_W + 1)'(b);
      if (sum[CNT_W]) return '1;
      else            return sum[CNT_W-1:0];
   endfunction

   logic [CNT_W-1:0] consumed_q, consumed_d;

   // Accumulates the amount actually removed (post-saturation) on each tick.
   always_comb begin
      consumed_d = consumed_q;
      if (wrap) consumed_d = sat_add(consumed_q, level_q - level_d);
   end

   // Drain counter register, cleared only by reset.
   always_ff @(posedge clk) begin
      if (reset) consumed_q <= '0;
      else       consumed_q <= consumed_d;
   end

   assign consumed_total = consumed_q;
`endif

endmodule

// File: tb/tb_battery_discharge_controller.sv
// Directed-vector bench for battery_discharge_controller: a default-parameter
// instance for the main scenarios and a LOW_THRESH=0/CUTOFF_LEVEL=0 instance
// for the saturation-at-empty scenario.
module tb_battery_discharge_controller;

   logic       clk = 1'b0;
   logic       reset;
   logic       cp, lr, ll;
   logic [1:0] lm;
   logic [7:0] li;
   logic [7:0] bl;
   logic       le, lb, dt;
   logic [1:0] ps;

   logic       z_cp, z_lr, z_ll;
   logic [1:0] z_lm;
   logic [7:0] z_li;
   logic [7:0] z_bl;
   logic       z_le, z_lb, z_dt;
   logic [1:0] z_ps;

`ifdef DRAIN_ACCOUNTING_EN
   logic [15:0] ct, z_ct;
`endif

   int checks = 0;
   int passes = 0;

   always #5 clk = ~clk;

   battery_discharge_controller dut (
      .clk(clk), .reset(reset), .charger_plugged(cp), .load_request(lr),
      .load_mode(lm), .level_load(ll), .level_in(li), .battery_level(bl),
      .load_enable(le), .low_battery(lb), .drain_tick(dt), .present_state(ps)
`ifdef DRAIN_ACCOUNTING_EN
      , .consumed_total(ct)
`endif
   );

   battery_discharge_controller #(.LOW_THRESH(0), .CUTOFF_LEVEL(0)) dut0 (
      .clk(clk), .reset(reset), .charger_plugged(z_cp), .load_request(z_lr),
      .load_mode(z_lm), .level_load(z_ll), .level_in(z_li), .battery_level(z_bl),
      .load_enable(z_le), .low_battery(z_lb), .drain_tick(z_dt), .present_state(z_ps)
`ifdef DRAIN_ACCOUNTING_EN
      , .consumed_total(z_ct)
`endif
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      step();
      step();
      checks++; if (bl !== 8'd100) $display("FAIL rst_level got %0d want 100", bl); else passes++;
      checks++; if (ps !== 2'b00) $display("FAIL rst_state got %0d want 0", ps); else passes++;
      checks++; if (le !== 1'b0) $display("FAIL rst_load_enable got %0b want 0", le); else passes++;
      checks++; if (lb !== 1'b0) $display("FAIL rst_low_battery got %0b want 0", lb); else passes++;
      checks++; if (dt !== 1'b0) $display("FAIL rst_drain_tick got %0b want 0", dt); else passes++;
      checks++; if (z_bl !== 8'd100) $display("FAIL rst_level_z got %0d want 100", z_bl); else passes++;
      reset = 1'b0;
   endtask

   task automatic test_discharge();
      lr = 1'b1; lm = 2'b10;
      step();
      checks++; if (ps !== 2'b01) $display("FAIL dis_enter_state got %0d want 1", ps); else passes++;
      checks++; if (le !== 1'b1) $display("FAIL dis_enter_le got %0b want 1", le); else passes++;
      checks++; if (bl !== 8'd100) $display("FAIL dis_enter_level got %0d want 100", bl); else passes++;
      for (int i = 0; i < 3; i++) begin
         step();
         checks++; if (dt !== 1'b0) $display("FAIL dis_pre_tick[%0d] got %0b want 0", i, dt); else passes++;
      end
      step();
      checks++; if (dt !== 1'b1) $display("FAIL dis_tick1 got %0b want 1", dt); else passes++;
      checks++; if (bl !== 8'd98) $display("FAIL dis_level1 got %0d want 98", bl); else passes++;
      step();
      checks++; if (dt !== 1'b0) $display("FAIL dis_tick_pulse got %0b want 0", dt); else passes++;
      step();
      step();
      step();
      checks++; if (dt !== 1'b1) $display("FAIL dis_tick2 got %0b want 1", dt); else passes++;
      checks++; if (bl !== 8'd96) $display("FAIL dis_level2 got %0d want 96", bl); else passes++;
      checks++; if (lb !== 1'b0) $display("FAIL dis_low got %0b want 0", lb); else passes++;
   endtask

   task automatic test_low_power_cutoff();
      bit hit;
      lm = 2'b11;
      hit = 1'b0;
      for (int i = 0; i < 200; i++) begin
         step();
         if (ps === 2'b10) begin hit = 1'b1; break; end
      end
      checks++; if (!hit) $display("FAIL lp_reach got timeout want LOW_POWER"); else passes++;
      checks++; if (bl !== 8'd18) $display("FAIL lp_enter_level got %0d want 18", bl); else passes++;
      checks++; if (lb !== 1'b1) $display("FAIL lp_low got %0b want 1", lb); else passes++;
      checks++; if (le !== 1'b1) $display("FAIL lp_le got %0b want 1", le); else passes++;
      step();
      step();
      step();
      checks++; if (dt !== 1'b1) $display("FAIL lp_tick got %0b want 1", dt); else passes++;
      checks++; if (bl !== 8'd17) $display("FAIL lp_rate1_level got %0d want 17", bl); else passes++;
      hit = 1'b0;
      for (int i = 0; i < 100; i++) begin
         step();
         if (ps === 2'b11) begin hit = 1'b1; break; end
      end
      checks++; if (!hit) $display("FAIL co_reach got timeout want CUTOFF"); else passes++;
      checks++; if (bl !== 8'd5) $display("FAIL co_level got %0d want 5", bl); else passes++;
      checks++; if (le !== 1'b0) $display("FAIL co_le got %0b want 0", le); else passes++;
      for (int i = 0; i < 8; i++) step();
      checks++; if (bl !== 8'd5) $display("FAIL co_frozen got %0d want 5", bl); else passes++;
   endtask

   task automatic test_cutoff_hold();
      for (int i = 0; i < 4; i++) begin
         lr = ~lr;
         step();
         checks++; if (ps !== 2'b11) $display("FAIL hold_state[%0d] got %0d want 3", i, ps); else passes++;
      end
      lr = 1'b1;
      cp = 1'b1;
      step();
      checks++; if (ps !== 2'b00) $display("FAIL plug_state got %0d want 0", ps); else passes++;
      checks++; if (le !== 1'b0) $display("FAIL plug_le got %0b want 0", le); else passes++;
      checks++; if (bl !== 8'd5) $display("FAIL plug_level got %0d want 5", bl); else passes++;
      checks++; if (dt !== 1'b0) $display("FAIL plug_tick got %0b want 0", dt); else passes++;
      step();
      checks++; if (ps !== 2'b00) $display("FAIL plug_stay got %0d want 0", ps); else passes++;
      cp = 1'b0;
      lr = 1'b0;
      step();
   endtask

   task automatic test_saturate_zero();
      z_ll = 1'b1; z_li = 8'd2;
      step();
      checks++; if (z_bl !== 8'd2) $display("FAIL sat_load got %0d want 2", z_bl); else passes++;
      checks++; if (z_lb !== 1'b0) $display("FAIL sat_low0 got %0b want 0", z_lb); else passes++;
      z_ll = 1'b0; z_lr = 1'b1; z_lm = 2'b11;
      step();
      checks++; if (z_ps !== 2'b01) $display("FAIL sat_enter got %0d want 1", z_ps); else passes++;
      step();
      step();
      step();
      step();
      checks++; if (z_bl !== 8'd0) $display("FAIL sat_level got %0d want 0", z_bl); else passes++;
      checks++; if (z_dt !== 1'b1) $display("FAIL sat_tick got %0b want 1", z_dt); else passes++;
      checks++; if (z_lb !== 1'b1) $display("FAIL sat_low1 got %0b want 1", z_lb); else passes++;
`ifdef DRAIN_ACCOUNTING_EN
      checks++; if (z_ct !== 16'd2) $display("FAIL sat_consumed got %0d want 2", z_ct); else passes++;
`endif
      step();
      checks++; if (z_ps !== 2'b10) $display("FAIL sat_lp got %0d want 2", z_ps); else passes++;
      step();
      checks++; if (z_ps !== 2'b11) $display("FAIL sat_co got %0d want 3", z_ps); else passes++;
      checks++; if (z_le !== 1'b0) $display("FAIL sat_co_le got %0b want 0", z_le); else passes++;
      z_lr = 1'b0; z_lm = 2'b00;
   endtask

   task automatic test_level_load_priority();
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
      lr = 1'b1; lm = 2'b10;
      step();
      step();
      step();
      step();
      ll = 1'b1; li = 8'd150;
      step();
      checks++; if (bl !== 8'd100) $display("FAIL ll_level got %0d want 100", bl); else passes++;
      checks++; if (dt !== 1'b0) $display("FAIL ll_tick got %0b want 0", dt); else passes++;
      ll = 1'b0; li = 8'd0;
      step();
      step();
      step();
      step();
      checks++; if (dt !== 1'b1) $display("FAIL ll_after_tick got %0b want 1", dt); else passes++;
      checks++; if (bl !== 8'd98) $display("FAIL ll_after_level got %0d want 98", bl); else passes++;
      for (int i = 0; i < 16; i++) step();
      checks++; if (bl !== 8'd90) $display("FAIL ll_run_level got %0d want 90", bl); else passes++;
`ifdef DRAIN_ACCOUNTING_EN
      checks++; if (ct !== 16'd10) $display("FAIL consumed got %0d want 10", ct); else passes++;
`endif
      reset = 1'b1;
      step();
      checks++; if (bl !== 8'd100) $display("FAIL midrst_level got %0d want 100", bl); else passes++;
      checks++; if (ps !== 2'b00) $display("FAIL midrst_state got %0d want 0", ps); else passes++;
      checks++; if (le !== 1'b0) $display("FAIL midrst_le got %0b want 0", le); else passes++;
`ifdef DRAIN_ACCOUNTING_EN
      checks++; if (ct !== 16'd0) $display("FAIL midrst_consumed got %0d want 0", ct); else passes++;
`endif
      reset = 1'b0;
      lr = 1'b0; lm = 2'b00;
      step();
   endtask

   initial begin
      reset = 1'b1;
      cp = 1'b0; lr = 1'b0; lm = 2'b00; ll = 1'b0; li = 8'd0;
      z_cp = 1'b0; z_lr = 1'b0; z_lm = 2'b00; z_ll = 1'b0; z_li = 8'd0;
      test_reset();
      test_discharge();
      test_low_power_cutoff();
      test_cutoff_hold();
      test_saturate_zero();
      test_level_load_priority();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
